// File: rtl/imem_boot_ctrl.sv
// Boot-load controller: assembles little-endian words from a UART byte stream,
// writes them to consecutive instruction RAM words and holds the core in reset meanwhile.
module imem_boot_ctrl #(
   parameter int DEPTH   = 64,
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 100000
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iStart,
   input  logic [ADDR_W:0]   iLen,
   input  logic [7:0]        iRxData,
   input  logic              iRxValid,
   output logic              oWrEn,
   output logic [ADDR_W-1:0] oWrAddr,
   output logic [31:0]       oWrData,
   output logic              oCpuRst_n,
   output logic              oBusy,
   output logic              oDone,
   output logic              oErr
);

   localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]  ONE_L    = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   state_t            state, state_nx;
   logic [ADDR_W:0]   len, len_nx;
   logic [ADDR_W:0]   word_idx, word_idx_nx;
   logic [1:0]        byte_idx, byte_idx_nx;
   logic [23:0]       asm_q, asm_nx;
   logic [GAP_W-1:0]  gap_cnt, gap_nx;
   logic              wr_en_nx;
   logic [ADDR_W-1:0] wr_addr_nx;
   logic [31:0]       wr_data_nx;

   always_comb begin
      state_nx    = state;
      len_nx      = len;
      word_idx_nx = word_idx;
      byte_idx_nx = byte_idx;
      asm_nx      = asm_q;
      gap_nx      = gap_cnt;
      wr_en_nx    = 1'b0;
      wr_addr_nx  = oWrAddr;
      wr_data_nx  = oWrData;
      case (state)
         IDLE, ERR: begin
            if (iStart && (iLen != '0)) begin
               state_nx    = LOAD;
               len_nx      = (iLen > DEPTH_L) ? DEPTH_L : iLen;
               word_idx_nx = '0;
               byte_idx_nx = '0;
               gap_nx      = '0;
            end
         end
         LOAD: begin
            if (iRxValid) begin
               gap_nx      = '0;
               byte_idx_nx = byte_idx + 2'd1;
               // Only three lanes are stored; the fourth byte goes straight into the write word.
               case (byte_idx)
                  2'd0: asm_nx[7:0]   = iRxData;
                  2'd1: asm_nx[15:8]  = iRxData;
                  2'd2: asm_nx[23:16] = iRxData;
                  default: begin
                     wr_en_nx    = 1'b1;
                     wr_addr_nx  = word_idx[ADDR_W-1:0];
                     wr_data_nx  = {iRxData, asm_q};
                     word_idx_nx = word_idx + ONE_L;
                     if (word_idx == (len - ONE_L)) state_nx = DONE;
                  end
               endcase
            end else if (gap_cnt == GAP_LAST) begin
               state_nx = ERR;
            end else begin
               gap_nx = gap_cnt + GAP_W'(1);
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state     <= IDLE;
         len       <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         asm_q     <= '0;
         gap_cnt   <= '0;
         oWrEn     <= 1'b0;
         oWrAddr   <= '0;
         oWrData   <= '0;
         oCpuRst_n <= 1'b0;
         oBusy     <= 1'b0;
         oDone     <= 1'b0;
         oErr      <= 1'b0;
      end else begin
         state     <= state_nx;
         len       <= len_nx;
         word_idx  <= word_idx_nx;
         byte_idx  <= byte_idx_nx;
         asm_q     <= asm_nx;
         gap_cnt   <= gap_nx;
         oWrEn     <= wr_en_nx;
         oWrAddr   <= wr_addr_nx;
         oWrData   <= wr_data_nx;
         oCpuRst_n <= (state_nx == IDLE);
         oBusy     <= (state_nx == LOAD);
         oDone     <= (state_nx == DONE);
         oErr      <= (state_nx == ERR);
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl (DEPTH=64, TIMEOUT=100).
module tb_imem_boot_ctrl;

   logic        iClk = 1'b0;
   logic        iRst_n;
   logic        iStart;
   logic [6:0]  iLen;
   logic [7:0]  iRxData;
   logic        iRxValid;
   logic        oWrEn;
   logic [5:0]  oWrAddr;
   logic [31:0] oWrData;
   logic        oCpuRst_n;
   logic        oBusy;
   logic        oDone;
   logic        oErr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [5:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          done_cnt;
   bit          err_seen;

   logic [7:0] stream [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};

   imem_boot_ctrl #(.DEPTH(64), .ADDR_W(6), .TIMEOUT(100)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iLen(iLen),
      .iRxData(iRxData), .iRxValid(iRxValid),
      .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
      .oCpuRst_n(oCpuRst_n), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
   );

   always #5 iClk = ~iClk;

   // Behaves like the RAM: captures whatever write port values are present at each edge.
   always @(posedge iClk) begin
      if (iRst_n) begin
         if (oWrEn) begin
            wa_q.push_back(oWrAddr);
            wd_q.push_back(oWrData);
         end
         if (oDone) done_cnt++;
         if (oErr) err_seen = 1'b1;
      end
   end

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      err_seen = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      iRxData  = b;
      iRxValid = 1'b1;
      @(posedge iClk);
      #1;
      iRxValid = 1'b0;
   endtask

   task automatic start(input logic [6:0] l);
      iStart = 1'b1;
      iLen   = l;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
   endtask

   task automatic test_reset();
      iRst_n = 1'b0; iStart = 1'b0; iLen = '0; iRxData = '0; iRxValid = 1'b0;
      #12;
      n_cmp++;
      if ({oCpuRst_n, oWrEn, oBusy, oDone, oErr, oWrAddr, oWrData} !== 43'd0) begin
         n_bad++;
         $display("FAIL reset_vals: got rst_n=%b en=%b busy=%b done=%b err=%b addr=%0d data=%h want all 0",
                  oCpuRst_n, oWrEn, oBusy, oDone, oErr, oWrAddr, oWrData);
      end
      iRst_n = 1'b1;
      #2;
      n_cmp++;
      if (oCpuRst_n !== 1'b0) begin n_bad++; $display("FAIL rst_release_early: got %b want 0", oCpuRst_n); end
      @(posedge iClk); #1;
      n_cmp++;
      if (oCpuRst_n !== 1'b1 || oBusy !== 1'b0) begin
         n_bad++; $display("FAIL rst_release_edge: got rst_n=%b busy=%b want 1 0", oCpuRst_n, oBusy);
      end
   endtask

   task automatic test_two_words();
      clear_log();
      start(7'd2);
      n_cmp++;
      if (oBusy !== 1'b1 || oCpuRst_n !== 1'b0) begin
         n_bad++; $display("FAIL tw_start: got busy=%b rst_n=%b want 1 0", oBusy, oCpuRst_n);
      end
      for (int i = 0; i < 8; i++) begin
         send_byte(stream[i]);
         if (i == 3) begin
            n_cmp++;
            if (oWrEn !== 1'b1 || oWrAddr !== 6'd0 || oWrData !== 32'h00500093 || oDone !== 1'b0 || oCpuRst_n !== 1'b0) begin
               n_bad++; $display("FAIL tw_w0: got en=%b addr=%0d data=%h done=%b rst_n=%b want 1 0 00500093 0 0",
                                 oWrEn, oWrAddr, oWrData, oDone, oCpuRst_n);
            end
         end
         if (i == 4) begin
            n_cmp++;
            if (oWrEn !== 1'b0) begin n_bad++; $display("FAIL tw_gap_en: got %b want 0", oWrEn); end
         end
      end
      n_cmp++;
      if (oWrEn !== 1'b1 || oWrAddr !== 6'd1 || oWrData !== 32'h00100113 || oDone !== 1'b1 || oCpuRst_n !== 1'b0 || oBusy !== 1'b0) begin
         n_bad++; $display("FAIL tw_w1: got en=%b addr=%0d data=%h done=%b rst_n=%b busy=%b want 1 1 00100113 1 0 0",
                           oWrEn, oWrAddr, oWrData, oDone, oCpuRst_n, oBusy);
      end
      idle(1);
      n_cmp++;
      if (oCpuRst_n !== 1'b1 || oDone !== 1'b0 || oWrEn !== 1'b0) begin
         n_bad++; $display("FAIL tw_release: got rst_n=%b done=%b en=%b want 1 0 0", oCpuRst_n, oDone, oWrEn);
      end
      n_cmp++;
      if (wa_q.size() != 2 || done_cnt != 1) begin
         n_bad++; $display("FAIL tw_count: got writes=%0d dones=%0d want 2 1", wa_q.size(), done_cnt);
      end
   endtask

   task automatic test_gaps();
      int g[8] = '{0, 3, 50, 7, 20, 12, 45, 4};
      clear_log();
      start(7'd2);
      for (int i = 0; i < 8; i++) begin
         idle(g[i]);
         send_byte(stream[i]);
      end
      idle(1);
      n_cmp++;
      if (wa_q.size() != 2 || err_seen || done_cnt != 1) begin
         n_bad++; $display("FAIL gap_count: got writes=%0d err=%b dones=%0d want 2 0 1", wa_q.size(), err_seen, done_cnt);
      end else begin
         n_cmp++;
         if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h00500093 || wa_q[1] !== 6'd1 || wd_q[1] !== 32'h00100113) begin
            n_bad++; $display("FAIL gap_data: got %0d:%h %0d:%h want 0:00500093 1:00100113", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
         end
      end
   endtask

   task automatic test_timeout();
      clear_log();
      start(7'd2);
      send_byte(8'h93);
      send_byte(8'h00);
      idle(99);
      n_cmp++;
      if (oErr !== 1'b0 || oBusy !== 1'b1) begin
         n_bad++; $display("FAIL to_99: got err=%b busy=%b want 0 1", oErr, oBusy);
      end
      idle(1);
      n_cmp++;
      if (oErr !== 1'b1 || oCpuRst_n !== 1'b0 || oBusy !== 1'b0) begin
         n_bad++; $display("FAIL to_100: got err=%b rst_n=%b busy=%b want 1 0 0", oErr, oCpuRst_n, oBusy);
      end
      for (int i = 0; i < 4; i++) send_byte(8'hee);
      idle(2);
      n_cmp++;
      if (wa_q.size() != 0 || oErr !== 1'b1) begin
         n_bad++; $display("FAIL to_nowrite: got writes=%0d err=%b want 0 1", wa_q.size(), oErr);
      end
      start(7'd1);
      n_cmp++;
      if (oErr !== 1'b0 || oBusy !== 1'b1) begin
         n_bad++; $display("FAIL to_restart: got err=%b busy=%b want 0 1", oErr, oBusy);
      end
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
      n_cmp++;
      if (oWrEn !== 1'b1 || oWrAddr !== 6'd0 || oWrData !== 32'h00000513 || oDone !== 1'b1) begin
         n_bad++; $display("FAIL to_rewrite: got en=%b addr=%0d data=%h done=%b want 1 0 00000513 1", oWrEn, oWrAddr, oWrData, oDone);
      end
      idle(1);
      n_cmp++;
      if (oCpuRst_n !== 1'b1 || oErr !== 1'b0 || wa_q.size() != 1) begin
         n_bad++; $display("FAIL to_release: got rst_n=%b err=%b writes=%0d want 1 0 1", oCpuRst_n, oErr, wa_q.size());
      end
   endtask

   task automatic test_timeout_edge();
      clear_log();
      start(7'd1);
      idle(99);
      send_byte(8'h37);
      n_cmp++;
      if (oErr !== 1'b0 || oBusy !== 1'b1) begin
         n_bad++; $display("FAIL te_saved: got err=%b busy=%b want 0 1", oErr, oBusy);
      end
      send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
      n_cmp++;
      if (oDone !== 1'b1 || oWrData !== 32'h00001237 || oWrAddr !== 6'd0) begin
         n_bad++; $display("FAIL te_write: got done=%b data=%h addr=%0d want 1 00001237 0", oDone, oWrData, oWrAddr);
      end
      idle(1);
   endtask

   task automatic test_len_zero();
      clear_log();
      start(7'd0);
      n_cmp++;
      if (oBusy !== 1'b0 || oCpuRst_n !== 1'b1) begin
         n_bad++; $display("FAIL lz_state: got busy=%b rst_n=%b want 0 1", oBusy, oCpuRst_n);
      end
      for (int i = 0; i < 4; i++) send_byte(stream[i]);
      idle(1);
      n_cmp++;
      if (wa_q.size() != 0 || oBusy !== 1'b0) begin
         n_bad++; $display("FAIL lz_nowrite: got writes=%0d busy=%b want 0 0", wa_q.size(), oBusy);
      end
   endtask

   task automatic test_len_clamp();
      logic [31:0] w;
      logic [7:0]  iv;
      clear_log();
      start(7'd100);
      for (int i = 0; i < 64; i++) begin
         iv = 8'(i);
         w  = {iv, 8'h5a, ~iv, 8'(i * 7)};
         for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
      end
      n_cmp++;
      if (oDone !== 1'b1 || oWrAddr !== 6'd63) begin
         n_bad++; $display("FAIL lc_done: got done=%b addr=%0d want 1 63", oDone, oWrAddr);
      end
      idle(1);
      n_cmp++;
      if (wa_q.size() != 64 || oBusy !== 1'b0 || done_cnt != 1) begin
         n_bad++; $display("FAIL lc_count: got writes=%0d busy=%b dones=%0d want 64 0 1", wa_q.size(), oBusy, done_cnt);
      end
      for (int i = 0; i < wa_q.size(); i++) begin
         iv = 8'(i);
         w  = {iv, 8'h5a, ~iv, 8'(i * 7)};
         n_cmp++;
         if (wa_q[i] !== 6'(i) || wd_q[i] !== w) begin
            n_bad++; $display("FAIL lc_word%0d: got %0d:%h want %0d:%h", i, wa_q[i], wd_q[i], i, w);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      start(7'd2);
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 5) begin
            iStart = 1'b1;
            iLen   = 7'd1;
         end
         send_byte(stream[i]);
         iStart = 1'b0;
      end
      n_cmp++;
      if (oDone !== 1'b1 || oWrAddr !== 6'd1 || oWrData !== 32'h00100113) begin
         n_bad++; $display("FAIL bb_done: got done=%b addr=%0d data=%h want 1 1 00100113", oDone, oWrAddr, oWrData);
      end
      idle(1);
      for (int i = 0; i < 4; i++) send_byte(stream[i]);
      idle(1);
      n_cmp++;
      if (wa_q.size() != 2 || wd_q[0] !== 32'h00500093 || oCpuRst_n !== 1'b1) begin
         n_bad++; $display("FAIL bb_log: got writes=%0d w0=%h rst_n=%b want 2 00500093 1", wa_q.size(), wd_q[0], oCpuRst_n);
      end
   endtask

   task automatic test_async_reset();
      clear_log();
      start(7'd4);
      for (int i = 0; i < 6; i++) send_byte(stream[i]);
      #2;
      iRst_n = 1'b0;
      #1;
      n_cmp++;
      if ({oCpuRst_n, oWrEn, oBusy, oDone, oErr, oWrAddr, oWrData} !== 43'd0) begin
         n_bad++; $display("FAIL ar_vals: got rst_n=%b en=%b busy=%b done=%b err=%b addr=%0d data=%h want all 0",
                           oCpuRst_n, oWrEn, oBusy, oDone, oErr, oWrAddr, oWrData);
      end
      #2;
      iRst_n = 1'b1;
      @(posedge iClk); #1;
      n_cmp++;
      if (oCpuRst_n !== 1'b1 || oBusy !== 1'b0) begin
         n_bad++; $display("FAIL ar_release: got rst_n=%b busy=%b want 1 0", oCpuRst_n, oBusy);
      end
      clear_log();
      start(7'd1);
      for (int i = 0; i < 4; i++) send_byte(stream[i]);
      n_cmp++;
      if (oWrEn !== 1'b1 || oWrAddr !== 6'd0 || oWrData !== 32'h00500093 || oDone !== 1'b1) begin
         n_bad++; $display("FAIL ar_reload: got en=%b addr=%0d data=%h done=%b want 1 0 00500093 1", oWrEn, oWrAddr, oWrData, oDone);
      end
      idle(1);
      n_cmp++;
      if (wa_q.size() != 1) begin n_bad++; $display("FAIL ar_count: got %0d want 1", wa_q.size()); end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_two_words();
      test_gaps();
      test_timeout();
      test_timeout_edge();
      test_len_zero();
      test_len_clamp();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load controller for the RV32I instruction memory. It takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words, and sequences them into consecutive words of the instruction RAM through its write port. While a load is in progress it holds the core in reset, and it releases the core once the last word is committed.

## Interface

Parameters:
- DEPTH, 64: instruction memory depth in words.
- ADDR_W, 6: word address width; clog2(DEPTH).
- TIMEOUT, 100000: number of consecutive idle cycles in LOAD that aborts the load.

Ports:
- iClk, input, 1: system clock. Single clock domain; all logic is rising-edge.
- iRst_n, input, 1: asynchronous active-low reset.
- iStart, input, 1: load request, one-cycle pulse. Sampled only in IDLE or ERR.
- iLen, input, ADDR_W+1: number of words to load. Latched on an accepted iStart.
- iRxData, input, 8: received byte.
- iRxValid, input, 1: one-cycle strobe qualifying iRxData.
- oWrEn, output, 1: instruction RAM write strobe, one cycle per word.
- oWrAddr, output, ADDR_W: word index being written.
- oWrData, output, 32: assembled instruction word.
- oCpuRst_n, output, 1: core reset, active-low. High only in IDLE.
- oBusy, output, 1: high in LOAD.
- oDone, output, 1: one-cycle pulse in DONE.
- oErr, output, 1: high in ERR.

## Operation

- States: IDLE, LOAD, DONE, ERR. All outputs are registered.
- IDLE:
  - The core runs (oCpuRst_n=1).
  - Bytes are ignored.
  - On iStart with iLen≠0:
    - Latch len = min(iLen, DEPTH).
    - Clear byte_idx, word_idx and gap_cnt.
    - Go to LOAD.
  - iStart with iLen=0 is ignored.
- LOAD:
  - oCpuRst_n=0 and oBusy=1.
  - Each iRxValid writes iRxData into byte lane byte_idx of the assembly register (first byte goes to [7:0]), increments byte_idx mod 4, and clears gap_cnt.
  - On the 4th byte:
    - oWrEn=1 on the next cycle, with oWrAddr=word_idx and oWrData=the complete word.
    - word_idx increments.
    - byte_idx returns to 0, so a byte arriving in the write cycle is byte 0 of the next word.
  - If that word was word len-1, go to DONE.
  - A cycle without iRxValid increments gap_cnt. If gap_cnt reaches TIMEOUT-1 with no byte in that cycle, go to ERR.
  - iStart is ignored in LOAD.
- DONE:
  - Lasts one cycle with oDone=1. The final oWrEn is issued in this cycle.
  - oCpuRst_n stays 0.
  - Next state is IDLE.
- ERR:
  - oErr=1 and oCpuRst_n=0 (the core is held).
  - On abort, any partial word is discarded. Words already written remain in RAM.
  - Bytes are ignored.
  - iStart with iLen≠0 clears oErr and starts a fresh load, exactly as from IDLE.
- oWrEn is never asserted outside LOAD or DONE. oWrAddr is always < len.

## Timing

- Reset (iRst_n=0, async): state=IDLE, oCpuRst_n=0, oWrEn=0, oWrAddr=0, oWrData=0, oBusy=0, oDone=0, oErr=0.
  - oCpuRst_n rises at the first clock edge after reset release.
- iStart sampled at edge t: state=LOAD from t. oCpuRst_n=0 and oBusy=1 are visible after edge t.
- 4th byte of a word sampled at edge k: oWrEn/oWrAddr/oWrData are valid for the cycle after edge k, and the RAM captures them at edge k+1.
- Last byte sampled at edge k:
  - After k: state DONE, oDone=1, final oWrEn=1.
  - After k+1: state IDLE, oCpuRst_n=1.
  - The core leaves reset one cycle after the final write lands.
- Throughput: a byte may be accepted every cycle. Back-to-back words therefore produce oWrEn at most every 4 cycles.
- Reset asserted mid-load: immediate return to reset values. The partial load is abandoned and RAM contents are left undefined for the unwritten words.
- Timeout: exactly TIMEOUT consecutive byte-free cycles in LOAD cause ERR. A byte in cycle TIMEOUT-1 prevents it.

## Test plan

- Load two words, len=2, bytes 93 00 50 00 13 01 10 00 on consecutive cycles -> write 0:0x00500093, then write 1:0x00100113 four cycles later. oDone pulses once with the second write. oCpuRst_n is 0 from start until one cycle after DONE.
- Irregular gaps: same stream with 3–50 idle cycles between bytes and TIMEOUT=100 -> identical writes, no oErr.
- Timeout: len=2, send 93 00 then stall 100 cycles -> oErr=1 and oCpuRst_n=0. The only write is none (partial word discarded). A restart with iStart and 4 bytes (len=1) -> write 0, oDone, oErr=0, core released.
- Boundaries:
  - iLen=0 -> ignored, state stays IDLE.
  - iLen=100 with DEPTH=64 -> exactly 64 writes, addresses 0..63, then DONE.
  - iStart and bytes during LOAD do not disturb the sequence.
- Async reset: assert iRst_n=0 after 6 bytes of a 4-word load -> all outputs at reset values immediately. After release, oCpuRst_n=1 next edge. A new load starts at address 0.
